// File: rtl/aes_block_loader.sv
// Byte-stream loader for the AES-128 encrypt core: assembles key and plaintext frames
// and offers each plaintext block over blk_valid/blk_ready. Optional AES_LOADER_TIMEOUT_EN adds an inter-byte abort.
module aes_block_loader #(
  parameter logic [7:0] HDR_KEY        = 8'h4B,
  parameter logic [7:0] HDR_PT         = 8'h50,
  parameter int         ERR_CNT_W      = 8,
  parameter int         TIMEOUT_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [127:0]         key,
  output logic                 key_valid,
  output logic [127:0]         plaintext,
  output logic                 blk_valid,
  input  logic                 blk_ready,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {IDLE, KEY, PT, DISCARD, HOLD} state_e;

  state_e                 state_q;
  logic [3:0]             cnt_q;
  logic [119:0]           kshadow_q, pshadow_q;
  logic [127:0]           key_q, pt_q;
  logic                   key_valid_q, blk_valid_q, err_q;
  logic [ERR_CNT_W-1:0]   err_cnt_q;
  logic                   xfer, busy, hdr_err, tmo_hit, err_d;

  assign in_ready  = rst_n && (state_q != HOLD);
  assign xfer      = in_valid && in_ready;
  assign busy      = (state_q == KEY) || (state_q == PT) || (state_q == DISCARD);
  // Any header other than a key, or a plaintext header before a key exists, is an error.
  assign hdr_err   = xfer && (state_q == IDLE) && (in_data != HDR_KEY) &&
                     !((in_data == HDR_PT) && key_valid_q);
  assign err_d     = hdr_err || tmo_hit;

`ifdef AES_LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;

  assign tmo_hit = busy && !xfer && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)    tmo_q <= '0;
    else if (busy) tmo_q <= (xfer || tmo_hit) ? '0 : tmo_q + TMO_W'(1);
  end
`else
  localparam int tmo_unused = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      kshadow_q   <= '0;
      pshadow_q   <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      pt_q        <= '0;
      blk_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_q <= err_d;
      if (err_d && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      case (state_q)
        IDLE: if (xfer) begin
          if (in_data == HDR_KEY)     state_q <= KEY;
          else if (in_data == HDR_PT) state_q <= key_valid_q ? PT : DISCARD;
        end
        KEY: if (xfer) begin
          cnt_q     <= cnt_q + 4'd1;
          kshadow_q <= {kshadow_q[111:0], in_data};
          if (cnt_q == 4'd15) begin
            key_q       <= {kshadow_q, in_data};
            key_valid_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        PT: if (xfer) begin
          cnt_q     <= cnt_q + 4'd1;
          pshadow_q <= {pshadow_q[111:0], in_data};
          if (cnt_q == 4'd15) begin
            pt_q        <= {pshadow_q, in_data};
            blk_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
        end
        DISCARD: if (xfer) begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_q <= IDLE;
        end
        HOLD: if (blk_ready) begin
          blk_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // Abort leaves key, key_valid and plaintext untouched.
      if (tmo_hit) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        kshadow_q <= '0;
        pshadow_q <= '0;
      end
    end
  end

  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign plaintext = pt_q;
  assign blk_valid = blk_valid_q;
  assign err       = err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_aes_block_loader.sv
// Scoreboard bench for aes_block_loader: frame-level reference model feeds an expected-block
// queue; a negedge monitor pops and compares on every block handshake and counts err pulses.
module tb_aes_block_loader;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic [7:0]   in_data = '0;
  logic         in_valid = 1'b0, blk_ready = 1'b0;
  logic         in_ready, key_valid, blk_valid, err;
  logic [127:0] key, plaintext;
  logic [7:0]   err_count;

  aes_block_loader #(.TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .key(key), .key_valid(key_valid), .plaintext(plaintext), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int err_seen = 0, err_tot = 0, err_sr = 0;
  int rdy_mode = 0, gap_max = 0;
  logic [255:0] exp_q[$];
  logic [255:0] e;
  logic [127:0] key_m = '0, pt_save;
  bit           keyv_m = 0;
  bit           prev_v = 0, prev_acc = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       blk_ready = 1'b0;
      1:       blk_ready = 1'b1;
      default: blk_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: err pulse counting, block scoreboard, blk_valid must not drop unaccepted.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err) err_seen++;
      if (prev_v && !prev_acc && !blk_valid) begin
        total++; bad++;
        $display("FAIL blk_valid_drop: got 0 want 1");
      end
      if (blk_valid && blk_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL blk_unexpected: got pt %h want no block", plaintext);
        end else begin
          e = exp_q.pop_front();
          chk("blk_key", key, e[255:128]);
          chk("blk_pt", plaintext, e[127:0]);
        end
      end
      prev_v   = blk_valid;
      prev_acc = blk_valid && blk_ready;
    end else begin
      prev_v = 0;
    end
  end

  task automatic send_byte(logic [7:0] b);
    int n = 0;
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
    while (!in_ready) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        total++; bad++;
        $display("FAIL in_ready_wait: got 0 want 1");
        return;
      end
    end
    in_data = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Reference model works per frame: expectations are recorded before the bytes go out.
  task automatic send_frame(logic [7:0] hdr, logic [127:0] d);
    if (hdr == 8'h4B) begin
      key_m = d; keyv_m = 1;
    end else if (hdr == 8'h50) begin
      if (keyv_m) exp_q.push_back({key_m, d});
      else begin err_tot++; err_sr++; end
    end else begin
      err_tot++; err_sr++;
    end
    send_byte(hdr);
    if (hdr == 8'h4B || hdr == 8'h50)
      for (int i = 15; i >= 0; i--) send_byte(d[i*8 +: 8]);
  endtask

  task automatic check_errs(string tag);
    #1;
    chk({tag, "_err_pulses"}, 128'(err_seen), 128'(err_tot));
    chk({tag, "_err_count"}, 128'(err_count), 128'((err_sr > 255) ? 255 : err_sr));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rst_in_ready", 128'(in_ready), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    key_m = '0; keyv_m = 0; err_sr = 0; exp_q.delete();
    chk("rst_key", key, '0);
    chk("rst_key_valid", 128'(key_valid), 128'(0));
    chk("rst_pt", plaintext, '0);
    chk("rst_blk_valid", 128'(blk_valid), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_err_count", 128'(err_count), 128'(0));
  endtask

  task automatic drain(string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    chk({tag, "_pending_blocks"}, 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d;
    logic [7:0]   h;
    int           r;
    do_reset();

    // Key load 00..0f.
    send_frame(8'h4B, 128'h000102030405060708090a0b0c0d0e0f);
    #1;
    chk("t1_key", key, 128'h000102030405060708090a0b0c0d0e0f);
    chk("t1_key_valid", 128'(key_valid), 128'(1));
    chk("t1_blk_valid", 128'(blk_valid), 128'(0));
    check_errs("t1");

    // Plaintext held until blk_ready.
    rdy_mode = 0;
    send_frame(8'h50, 128'h00112233445566778899aabbccddeeff);
    #1;
    chk("t2_pt", plaintext, 128'h00112233445566778899aabbccddeeff);
    chk("t2_blk_valid", 128'(blk_valid), 128'(1));
    chk("t2_in_ready", 128'(in_ready), 128'(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_hold_pt", plaintext, 128'h00112233445566778899aabbccddeeff);
      chk("t2_hold_v", 128'(blk_valid), 128'(1));
    end
    rdy_mode = 1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("t2_acc_v", 128'(blk_valid), 128'(0));
    chk("t2_acc_rdy", 128'(in_ready), 128'(1));
    chk("t2_pending", 128'(exp_q.size()), 128'(0));

    // Plaintext before any key is discarded with one error.
    do_reset();
    send_frame(8'h50, {16{8'hAA}});
    #1;
    chk("t3_pt", plaintext, '0);
    chk("t3_blk_valid", 128'(blk_valid), 128'(0));
    check_errs("t3");
    send_frame(8'h4B, 128'hfedcba98765432100123456789abcdef);
    #1;
    chk("t3_key", key, 128'hfedcba98765432100123456789abcdef);
    check_errs("t3b");

    // Error counter saturation.
    send_frame(8'h00, '0);
    send_frame(8'h7F, '0);
    for (int i = 0; i < 300; i++) send_frame(8'h01, '0);
    check_errs("t4");
    chk("t4_sat", 128'(err_count), 128'(255));

    // Reset in the middle of a key frame.
    send_byte(8'h4B);
    for (int i = 0; i < 8; i++) send_byte(8'(i + 8'h30));
    do_reset();
    send_frame(8'h4B, 128'h0f0e0d0c0b0a09080706050403020100);
    #1;
    chk("t5_key", key, 128'h0f0e0d0c0b0a09080706050403020100);
    chk("t5_key_valid", 128'(key_valid), 128'(1));
    check_errs("t5");

`ifdef AES_LOADER_TIMEOUT_EN
    pt_save = plaintext;
    send_byte(8'h50);
    for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i));
    err_tot++; err_sr++;
    repeat (25) @(negedge clk);
    chk("t6_pt", plaintext, pt_save);
    chk("t6_blk_valid", 128'(blk_valid), 128'(0));
    chk("t6_key", key, key_m);
    check_errs("t6");
    rdy_mode = 1;
    send_frame(8'h50, 128'h13579bdf02468ace13579bdf02468ace);
    drain("t6");
    check_errs("t6b");
`endif

    // Randomized frames with random gaps and random blk_ready.
    gap_max  = 2;
    rdy_mode = 2;
    for (int f = 0; f < 40; f++) begin
      r = $urandom_range(0, 9);
      d = {$urandom, $urandom, $urandom, $urandom};
      if (r < 3)      h = 8'h4B;
      else if (r < 8) h = 8'h50;
      else begin
        h = 8'($urandom);
        if (h == 8'h4B || h == 8'h50) h = 8'h00;
      end
      send_frame(h, d);
    end
    drain("rand");
    #1;
    chk("rand_key", key, key_m);
    chk("rand_key_valid", 128'(key_valid), 128'(keyv_m));
    check_errs("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
